// File: rtl/user_pulser.sv
// user_pulser: three-phase programmable pulse-train generator.
// A start strobe (accepted in IDLE or DONE) latches the configuration. The
// block then runs f1_count periods of F1, f2_count periods of F2 (only when
// enable_f2), and stop_count quiet periods, and finally parks in DONE.
// A period is (*_end + 1) cycles; the output is high for the first *_high
// cycles of each F1/F2 period.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 one-cycle start strobe
//   f1_count/f2_count/stop_count   periods per phase (0 skips the phase)
//   f1_end/f1_high, f2_end/f2_high period length-1 and high time per waveform
//   enable_f2             run F2 and use F2 timing for STOP (else F1 timing)
//   pulse_out             generated pulse train, decoded from registers only
module user_pulser #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] f1_count,
  input  logic [CNT_W-1:0] f2_count,
  input  logic [CNT_W-1:0] stop_count,
  input  logic [CNT_W-1:0] f1_end,
  input  logic [CNT_W-1:0] f1_high,
  input  logic [CNT_W-1:0] f2_end,
  input  logic [CNT_W-1:0] f2_high,
  input  logic             enable_f2,
  output logic             pulse_out
);

  typedef enum logic [2:0] {IDLE, F1, F2, STOP, DONE} state_t;

  state_t           state, w_state_nxt;
  logic [CNT_W-1:0] r_pcnt, r_phcnt;
  logic [CNT_W-1:0] w_pcnt_nxt, w_phcnt_nxt, w_phcnt_inc;
  logic [CNT_W-1:0] w_end, w_cnt;
  logic             w_go;

  // latched configuration
  logic [CNT_W-1:0] r_f1_count, r_f2_count, r_stop_count;
  logic [CNT_W-1:0] r_f1_end, r_f1_high, r_f2_end, r_f2_high;
  logic             r_en_f2;

  // First non-empty phase strictly after 'cur' in the order F1, F2, STOP.
  // IDLE/DONE mean "before F1" (used at start).
  function automatic state_t next_phase(input state_t cur,
                                        input logic [CNT_W-1:0] c1,
                                        input logic [CNT_W-1:0] c2,
                                        input logic [CNT_W-1:0] cs,
                                        input logic en);
    next_phase = DONE;
    if ((cur == IDLE || cur == DONE) && c1 != '0)
      next_phase = F1;
    else if ((cur == IDLE || cur == DONE || cur == F1) && en && c2 != '0)
      next_phase = F2;
    else if (cur != STOP && cs != '0)
      next_phase = STOP;
  endfunction

  assign w_go        = start && (state == IDLE || state == DONE);
  assign w_phcnt_inc = r_phcnt + 1'b1;

  // period end and period count of the running phase
  always_comb begin
    w_end = '0;
    w_cnt = '0;
    case (state)
      F1:      begin w_end = r_f1_end; w_cnt = r_f1_count; end
      F2:      begin w_end = r_f2_end; w_cnt = r_f2_count; end
      STOP:    begin w_end = r_en_f2 ? r_f2_end : r_f1_end; w_cnt = r_stop_count; end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = state;
    w_pcnt_nxt  = r_pcnt;
    w_phcnt_nxt = r_phcnt;
    if (w_go) begin
      // phase selection uses the live inputs, which are latched this same edge
      w_state_nxt = next_phase(IDLE, f1_count, f2_count, stop_count, enable_f2);
      w_pcnt_nxt  = '0;
      w_phcnt_nxt = '0;
    end else if (state == F1 || state == F2 || state == STOP) begin
      if (r_pcnt == w_end) begin
        w_pcnt_nxt = '0;
        if (w_phcnt_inc == w_cnt) begin
          w_state_nxt = next_phase(state, r_f1_count, r_f2_count, r_stop_count, r_en_f2);
          w_phcnt_nxt = '0;
        end else begin
          w_phcnt_nxt = w_phcnt_inc;
        end
      end else begin
        w_pcnt_nxt = r_pcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_pcnt  <= '0;
      r_phcnt <= '0;
    end else begin
      state   <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_phcnt <= w_phcnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f1_count   <= '0;
      r_f2_count   <= '0;
      r_stop_count <= '0;
      r_f1_end     <= '0;
      r_f1_high    <= '0;
      r_f2_end     <= '0;
      r_f2_high    <= '0;
      r_en_f2      <= 1'b0;
    end else if (w_go) begin
      r_f1_count   <= f1_count;
      r_f2_count   <= f2_count;
      r_stop_count <= stop_count;
      r_f1_end     <= f1_end;
      r_f1_high    <= f1_high;
      r_f2_end     <= f2_end;
      r_f2_high    <= f2_high;
      r_en_f2      <= enable_f2;
    end
  end

  assign pulse_out = (state == F1 && r_pcnt < r_f1_high) ||
                     (state == F2 && r_pcnt < r_f2_high);

endmodule

// File: tb/tb_user_pulser.sv
// Bench for user_pulser: a per-cycle expected waveform queue is built from
// the phase rules for each run and compared against pulse_out every cycle;
// literal cycle/high-count expectations pin the model itself.
module tb_user_pulser;
  localparam int ST_IDLE = 0;
  localparam int ST_DONE = 4;

  logic       clk = 1'b0;
  logic       rst_n, start, enable_f2, pulse_out;
  logic [7:0] f1_count, f2_count, stop_count, f1_end, f1_high, f2_end, f2_high;

  user_pulser #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .f1_count(f1_count), .f2_count(f2_count), .stop_count(stop_count),
    .f1_end(f1_end), .f1_high(f1_high), .f2_end(f2_end), .f2_high(f2_high),
    .enable_f2(enable_f2), .pulse_out(pulse_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk   = 1'b0;
  bit exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output, one entry per cycle after the start edge until DONE.
  task automatic build_model(input int c1, e1, h1, c2, e2, h2, cs, input bit en);
    exp_q.delete();
    for (int p = 0; p < c1; p++)
      for (int c = 0; c <= e1; c++) exp_q.push_back(c < h1);
    if (en)
      for (int p = 0; p < c2; p++)
        for (int c = 0; c <= e2; c++) exp_q.push_back(c < h2);
    for (int i = 0; i < cs * ((en ? e2 : e1) + 1); i++) exp_q.push_back(1'b0);
  endtask

  // Single compare process: waveform while the model has cycles, then DONE.
  always @(negedge clk) begin
    if (chk && rst_n) begin
      if (exp_q.size() > 0) begin
        bit e;
        e = exp_q.pop_front();
        check("pulse", pulse_out, int'(e));
        check("not_done_yet", (dut.state != ST_DONE), 1);
      end else begin
        check("done_pulse", pulse_out, 0);
        check("done_state", dut.state, ST_DONE);
      end
    end
  end

  task automatic drive_cfg(input int c1, e1, h1, c2, e2, h2, cs, input bit en);
    f1_count = 8'(c1); f1_end = 8'(e1); f1_high = 8'(h1);
    f2_count = 8'(c2); f2_end = 8'(e2); f2_high = 8'(h2);
    stop_count = 8'(cs); enable_f2 = en;
  endtask

  // Start a run and wait for DONE; optionally scramble inputs mid-run.
  task automatic run(input int c1, e1, h1, c2, e2, h2, cs, input bit en, input bit noise,
                     output int n, output int hi, output int qlen, output int first);
    bit done;
    @(negedge clk);
    drive_cfg(c1, e1, h1, c2, e2, h2, cs, en);
    start = 1'b1;
    @(posedge clk);
    build_model(c1, e1, h1, c2, e2, h2, cs, en);
    qlen = exp_q.size();
    chk  = 1'b1;
    n = 0; hi = 0; first = -1; done = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (k == 0) first = int'(pulse_out);
      if (dut.state == ST_DONE) begin
        start = 1'b0;
        done  = 1'b1;
        break;
      end
      if (noise && k > 0) begin
        start = 1'($urandom);
        drive_cfg($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9),
                  $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9),
                  $urandom_range(0, 3), 1'($urandom));
      end else begin
        start = 1'b0;
      end
      hi += int'(pulse_out);
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, hi, ql, fs;
    rst_n = 1'b0;
    start = 1'b1;  // start during reset must be ignored
    drive_cfg(3, 50, 15, 3, 25, 5, 3, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", dut.state, ST_IDLE);
    check("reset_pulse", pulse_out, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", dut.state, ST_IDLE);

    // all phases
    run(3, 50, 15, 3, 25, 5, 3, 1'b1, 1'b0, n, hi, ql, fs);
    check("t1_model_len", ql, 309);
    check("t1_cycles", n, 309);
    check("t1_high", hi, 60);
    check("t1_first", fs, 1);

    // F2 disabled, started from DONE
    run(4, 40, 10, 0, 25, 5, 2, 1'b0, 1'b0, n, hi, ql, fs);
    check("t2_model_len", ql, 246);
    check("t2_cycles", n, 246);
    check("t2_high", hi, 40);

    // skip F1
    run(0, 50, 15, 2, 25, 5, 2, 1'b1, 1'b0, n, hi, ql, fs);
    check("t3_cycles", n, 104);
    check("t3_high", hi, 10);
    check("t3_first_f2", fs, 1);

    // all counts zero
    run(0, 5, 3, 0, 5, 3, 0, 1'b1, 1'b0, n, hi, ql, fs);
    check("t4_cycles", n, 0);
    check("t4_high", hi, 0);

    // randomized runs with inputs scrambled during the run
    for (int r = 0; r < 10; r++)
      run($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9),
          $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 9),
          $urandom_range(0, 3), 1'($urandom), 1'b1, n, hi, ql, fs);

    // abort in the middle of F2 (cycle 155: second cycle of first F2 period)
    @(negedge clk);
    drive_cfg(3, 50, 15, 3, 25, 5, 3, 1'b1);
    start = 1'b1;
    @(posedge clk);
    build_model(3, 50, 15, 3, 25, 5, 3, 1'b1);
    chk = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (154) @(negedge clk);
    #2;
    chk = 1'b0;
    exp_q.delete();
    check("abort_pre_pulse", pulse_out, 1);
    rst_n = 1'b0;
    #1;
    check("abort_pulse", pulse_out, 0);
    check("abort_state", dut.state, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    run(3, 50, 15, 3, 25, 5, 3, 1'b1, 1'b0, n, hi, ql, fs);
    check("rerun_cycles", n, 309);
    check("rerun_high", hi, 60);

    repeat (3) @(negedge clk);
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/user_pulser.md
Name: user_pulser

Overview:
- Programmable three-phase pulse-train generator for the user domain.
- On `start` it emits `f1_count` periods of waveform F1, then `f2_count` periods of waveform F2, then `stop_count` quiet periods, and finally parks in DONE.
- Each waveform is defined by a period length (`*_end`) and a high time (`*_high`), counted in clock cycles.
- Configuration is supplied by user-domain registers; `pulse_out` drives a pad or downstream logic.

Parameters:
- CNT_W, 8, width of all count and timing inputs and of the internal counters.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start strobe; sampled only in IDLE or DONE.
- f1_count  in  CNT_W  number of F1 periods.
- f2_count  in  CNT_W  number of F2 periods.
- stop_count  in  CNT_W  number of quiet STOP periods.
- f1_end  in  CNT_W  F1 period is f1_end+1 cycles.
- f1_high  in  CNT_W  F1 high cycles per period.
- f2_end  in  CNT_W  F2 period is f2_end+1 cycles.
- f2_high  in  CNT_W  F2 high cycles per period.
- enable_f2  in  1  1 = run the F2 phase and use F2 timing for STOP; 0 = skip F2 and use F1 timing for STOP.
- pulse_out  out  1  generated pulse train.

Behaviour:
- State register is named `state` and is enumerated IDLE, F1, F2, STOP, DONE. Benches probe `state` and the DONE constant hierarchically, so both names are fixed.
- Reset (async, rst_n=0):
  - state=IDLE; period counter and phase counter = 0; all latched config = 0.
  - pulse_out=0 immediately.
  - Reset asserted mid-sequence aborts the sequence.
- Start:
  - In IDLE or DONE, `start`=1 at a rising edge latches all config inputs.
  - Next state is the first non-empty phase, checked in order: F1 if f1_count≠0; else F2 if enable_f2 and f2_count≠0; else STOP if stop_count≠0; else DONE.
  - Period counter and phase counter clear to 0.
  - `start` is ignored in F1, F2 and STOP. Input changes during a run have no effect until the next start.
- Period counter `pcnt` (0..end):
  - Increments every cycle while in F1, F2 or STOP.
  - When pcnt==end it wraps to 0 and the phase counter increments.
  - When the phase counter reaches the phase's count on that wrap, the FSM moves to the next non-empty phase (same order as at start, then DONE). Both counters clear on the move.
  - end=0 gives a 1-cycle period.
- STOP timing uses (f2_end) when enable_f2=1, else (f1_end).
- pulse_out decode (no input-to-output path):
  - pulse_out = (state==F1 && pcnt<f1_high) || (state==F2 && pcnt<f2_high).
  - Decoded combinationally from registered state, counter and latched config.
  - pulse_out=0 in IDLE, STOP and DONE.
  - high=0 gives a constant low phase; high>end gives a constant high phase.
- Latency: the first pulse_out high cycle is the cycle immediately after the start edge.
- Phase durations: a phase with count N lasts N*(end+1) cycles, with no gap cycles between phases.
- DONE:
  - Entered on the edge after the last STOP (or last active phase) cycle.
  - Stays in DONE with pulse_out=0 until the next start.
- No overflow: counters are CNT_W wide and compare exactly; a count of 0 skips the phase.

Test Plan:
- Reset: rst_n low for 2 cycles -> state=IDLE, pulse_out=0; a start while in reset is ignored.
- All phases: f1=3/50/15, f2=3/25/5, stop=3, enable_f2=1, 1-cycle start.
  - F1 phase: 3× (15 high, 36 low).
  - F2 phase: 3× (5 high, 21 low).
  - STOP phase: 78 low cycles.
  - DONE reached exactly 309 cycles after the start edge.
- F2 disabled: f1=4/40/10, f2_count=0, stop=2, enable_f2=0, started from DONE.
  - F1 phase: 4× (10 high, 31 low).
  - STOP phase: 82 low cycles (F1 timing).
  - DONE after 246 cycles; exactly 40 high cycles in total.
- Skip F1: f1_count=0, f2=2/25/5, stop=2, enable_f2=1.
  - F2 starts the cycle after start.
  - DONE after 104 cycles; exactly 10 high cycles.
- All counts zero: start -> DONE on the next edge, pulse_out never high.
- Abort: rst_n low in the middle of F2 -> pulse_out=0 immediately, state=IDLE; a new start runs a complete sequence.
